// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Central stall/flush sequencer for the 5-stage MangoMIPS32
//               pipeline. Resolves stall requests from IF/ID/EX/MEM, accepts
//               MEM-stage exception/ERET redirects (deferred while a data-bus
//               transaction is in flight), issues the PC redirect and a
//               mul/div cancel pulse, and counts stalled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32,
    parameter int NREG  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic             id_req,
    input  logic             ex_req,
    input  logic             mem_req,
    input  logic             exc_req,
    input  logic [31:0]      exc_pc,
    output logic [NREG-1:0]  stall,
    output logic [NREG-1:0]  flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             ex_cancel,
    output logic             exc_ack,
    output logic [CNT_W-1:0] stall_cnt
);

    // Bit order of stall/flush: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB.
    // A request at stage k freezes everything upstream of and including the
    // k-th register boundary and inserts a bubble into the register after it.
    localparam logic [NREG-1:0] c_stall_mem = 5'b01111;
    localparam logic [NREG-1:0] c_flush_mem = 5'b10000;
    localparam logic [NREG-1:0] c_stall_ex  = 5'b00111;
    localparam logic [NREG-1:0] c_flush_ex  = 5'b01000;
    localparam logic [NREG-1:0] c_stall_id  = 5'b00011;
    localparam logic [NREG-1:0] c_flush_id  = 5'b00100;
    localparam logic [NREG-1:0] c_stall_if  = 5'b00001;
    localparam logic [NREG-1:0] c_flush_if  = 5'b00010;
    localparam logic [NREG-1:0] c_flush_all = {NREG{1'b1}};

    // RUN: normal hazard arbitration. EXC_WAIT: exception pending behind a
    // data-bus transaction that cannot be aborted. REDIRECT: single-cycle PC
    // load. The fourth encoding is never entered and falls back to RUN.
    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_EXC_WAIT = 2'd1,
        S_REDIRECT = 2'd2,
        S_UNUSED   = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [31:0]      redirect_pc_q;
    logic [31:0]      redirect_pc_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic [NREG-1:0]  run_stall;
    logic [NREG-1:0]  run_flush;

    // Ordinary hazard pattern: the most downstream requester wins.
    always_comb begin
        run_stall = '0;
        run_flush = '0;
        if (mem_req) begin
            run_stall = c_stall_mem;
            run_flush = c_flush_mem;
        end else if (ex_req) begin
            run_stall = c_stall_ex;
            run_flush = c_flush_ex;
        end else if (id_req) begin
            run_stall = c_stall_id;
            run_flush = c_flush_id;
        end else if (if_req) begin
            run_stall = c_stall_if;
            run_flush = c_flush_if;
        end
    end

    // Next-state and output decode; exception acceptance kills every younger
    // instruction, so it overrides the ordinary hazard pattern entirely.
    always_comb begin
        state_d        = state_q;
        redirect_pc_d  = redirect_pc_q;
        stall          = '0;
        flush          = '0;
        ex_cancel      = 1'b0;
        exc_ack        = 1'b0;
        redirect_valid = 1'b0;

        case (state_q)
            S_RUN: begin
                if (exc_req && !mem_req) begin
                    flush         = c_flush_all;
                    ex_cancel     = 1'b1;
                    exc_ack       = 1'b1;
                    redirect_pc_d = exc_pc;
                    state_d       = S_REDIRECT;
                end else if (exc_req) begin
                    stall   = c_stall_mem;
                    flush   = c_flush_mem;
                    state_d = S_EXC_WAIT;
                end else begin
                    stall = run_stall;
                    flush = run_flush;
                end
            end

            S_EXC_WAIT: begin
                if (!exc_req) begin
                    // MEM withdrew its request: abandon it without an ack.
                    stall   = run_stall;
                    flush   = run_flush;
                    state_d = S_RUN;
                end else if (mem_req) begin
                    stall = c_stall_mem;
                    flush = c_flush_mem;
                end else begin
                    flush         = c_flush_all;
                    ex_cancel     = 1'b1;
                    exc_ack       = 1'b1;
                    redirect_pc_d = exc_pc;
                    state_d       = S_REDIRECT;
                end
            end

            S_REDIRECT: begin
                // All requests are ignored while the PC is being reloaded.
                redirect_valid = 1'b1;
                flush          = c_flush_all;
                state_d        = S_RUN;
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Performance counter: counts only cycles where something is frozen.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (|stall) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State, latched redirect target and stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_RUN;
            redirect_pc_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign redirect_pc = redirect_pc_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl. A second
//               instance with a 4-bit counter exercises counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        r_rst;
    logic        r_if_req;
    logic        r_id_req;
    logic        r_ex_req;
    logic        r_mem_req;
    logic        r_exc_req;
    logic [31:0] r_exc_pc;

    logic [4:0]  w_stall;
    logic [4:0]  w_flush;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_ex_cancel;
    logic        w_exc_ack;
    logic [31:0] w_stall_cnt;

    logic [4:0]  w4_stall;
    logic [4:0]  w4_flush;
    logic        w4_redirect_valid;
    logic [31:0] w4_redirect_pc;
    logic        w4_ex_cancel;
    logic        w4_exc_ack;
    logic [3:0]  w4_stall_cnt;

    int n_checks = 0;
    int n_fails  = 0;
    int exp_cnt  = 0;

    logic r_prev_wait = 1'b0;

    // {mem,ex,id,if} request vector, expected stall, expected flush
    logic [13:0] c_tab [6] = '{
        {4'b0001, 5'b00001, 5'b00010},
        {4'b0010, 5'b00011, 5'b00100},
        {4'b0011, 5'b00011, 5'b00100},
        {4'b1011, 5'b01111, 5'b10000},
        {4'b0100, 5'b00111, 5'b01000},
        {4'b1000, 5'b01111, 5'b10000}
    };

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(32), .NREG(5)) u_dut (
        .clk            (clk),
        .rst            (r_rst),
        .if_req         (r_if_req),
        .id_req         (r_id_req),
        .ex_req         (r_ex_req),
        .mem_req        (r_mem_req),
        .exc_req        (r_exc_req),
        .exc_pc         (r_exc_pc),
        .stall          (w_stall),
        .flush          (w_flush),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .ex_cancel      (w_ex_cancel),
        .exc_ack        (w_exc_ack),
        .stall_cnt      (w_stall_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4), .NREG(5)) u_dut4 (
        .clk            (clk),
        .rst            (r_rst),
        .if_req         (r_if_req),
        .id_req         (r_id_req),
        .ex_req         (r_ex_req),
        .mem_req        (r_mem_req),
        .exc_req        (r_exc_req),
        .exc_pc         (r_exc_pc),
        .stall          (w4_stall),
        .flush          (w4_flush),
        .redirect_valid (w4_redirect_valid),
        .redirect_pc    (w4_redirect_pc),
        .ex_cancel      (w4_ex_cancel),
        .exc_ack        (w4_exc_ack),
        .stall_cnt      (w4_stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fails++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Checks the stall/flush pair and advances the expected stall count.
    task automatic check_pat(input string tag, input logic [4:0] es, input logic [4:0] ef);
        check_eq({tag, "_stall"}, {27'd0, w_stall}, {27'd0, es});
        check_eq({tag, "_flush"}, {27'd0, w_flush}, {27'd0, ef});
        if (es != 5'd0) exp_cnt++;
    endtask

    task automatic drive_reqs(input logic [3:0] v);
        {r_mem_req, r_ex_req, r_id_req, r_if_req} = v;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // MEM must hold exc_req while its exception is parked behind the bus.
    always @(negedge clk) begin
        assert (r_rst || !r_prev_wait || r_exc_req)
        else $display("FAIL exc_req_withdrawn_while_waiting: observed 0 expected 1");
        r_prev_wait <= !r_rst && r_exc_req && (w_stall == 5'b01111) && !w_exc_ack;
    end

    initial begin
        r_rst = 1'b1;
        r_exc_req = 1'b0;
        r_exc_pc = 32'd0;
        drive_reqs(4'b0000);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_stall", {27'd0, w_stall}, 32'd0);
        check_eq("rst_flush", {27'd0, w_flush}, 32'd0);
        check_eq("rst_rv", {31'd0, w_redirect_valid}, 32'd0);
        check_eq("rst_rpc", w_redirect_pc, 32'd0);
        check_eq("rst_cancel", {31'd0, w_ex_cancel}, 32'd0);
        check_eq("rst_ack", {31'd0, w_exc_ack}, 32'd0);
        check_eq("rst_cnt", w_stall_cnt, 32'd0);
        next_cyc();
        r_rst = 1'b0;

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_pat("idle", 5'b00000, 5'b00000);
            next_cyc();
        end
        check_eq("idle_cnt", w_stall_cnt, 32'd0);

        // ex_req with id_req for 4 cycles: EX wins
        drive_reqs(4'b0110);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_pat("exid", 5'b00111, 5'b01000);
            next_cyc();
        end
        drive_reqs(4'b0000);
        check_eq("exid_cnt", w_stall_cnt, 32'd4);

        // Priority table
        for (int i = 0; i < 6; i++) begin
            logic [13:0] e;
            e = c_tab[i];
            drive_reqs(e[13:10]);
            @(negedge clk);
            check_pat("prio", e[9:5], e[4:0]);
            next_cyc();
        end
        drive_reqs(4'b0000);
        check_eq("prio_cnt", w_stall_cnt, exp_cnt);

        // Exception accepted immediately; dominates ex_req
        r_exc_req = 1'b1;
        r_exc_pc  = 32'hBFC0_0380;
        r_ex_req  = 1'b1;
        @(negedge clk);
        check_pat("acc", 5'b00000, 5'b11111);
        check_eq("acc_ack", {31'd0, w_exc_ack}, 32'd1);
        check_eq("acc_cancel", {31'd0, w_ex_cancel}, 32'd1);
        check_eq("acc_rv", {31'd0, w_redirect_valid}, 32'd0);
        next_cyc();
        r_exc_req = 1'b0;
        r_ex_req  = 1'b0;
        r_mem_req = 1'b1;
        @(negedge clk);
        check_pat("redir", 5'b00000, 5'b11111);
        check_eq("redir_rv", {31'd0, w_redirect_valid}, 32'd1);
        check_eq("redir_pc", w_redirect_pc, 32'hBFC0_0380);
        check_eq("redir_ack", {31'd0, w_exc_ack}, 32'd0);
        next_cyc();
        r_mem_req = 1'b0;
        r_id_req  = 1'b1;
        @(negedge clk);
        check_pat("post", 5'b00011, 5'b00100);
        check_eq("post_rv", {31'd0, w_redirect_valid}, 32'd0);
        check_eq("post_pc_hold", w_redirect_pc, 32'hBFC0_0380);
        next_cyc();
        r_id_req = 1'b0;

        // Exception deferred by 3 cycles of bus activity
        r_exc_req = 1'b1;
        r_exc_pc  = 32'h8000_0180;
        r_mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_pat("wait", 5'b01111, 5'b10000);
            check_eq("wait_ack", {31'd0, w_exc_ack}, 32'd0);
            next_cyc();
        end
        r_mem_req = 1'b0;
        @(negedge clk);
        check_pat("wacc", 5'b00000, 5'b11111);
        check_eq("wacc_ack", {31'd0, w_exc_ack}, 32'd1);
        check_eq("wacc_cancel", {31'd0, w_ex_cancel}, 32'd1);
        next_cyc();
        r_exc_req = 1'b0;
        @(negedge clk);
        check_eq("wredir_rv", {31'd0, w_redirect_valid}, 32'd1);
        check_eq("wredir_pc", w_redirect_pc, 32'h8000_0180);
        next_cyc();
        check_eq("wait_cnt", w_stall_cnt, exp_cnt);

        // Asynchronous reset while an exception waits on the bus
        r_exc_req = 1'b1;
        r_exc_pc  = 32'h1234_5678;
        r_mem_req = 1'b1;
        @(negedge clk);
        check_pat("prerst", 5'b01111, 5'b10000);
        next_cyc();
        #2;
        r_rst = 1'b1;
        r_exc_req = 1'b0;
        r_mem_req = 1'b0;
        exp_cnt = 0;
        #1;
        check_eq("arst_stall", {27'd0, w_stall}, 32'd0);
        check_eq("arst_flush", {27'd0, w_flush}, 32'd0);
        check_eq("arst_rpc", w_redirect_pc, 32'd0);
        check_eq("arst_cnt", w_stall_cnt, 32'd0);
        check_eq("arst_ack", {31'd0, w_exc_ack}, 32'd0);
        next_cyc();
        r_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_pat("postrst", 5'b00000, 5'b00000);
            check_eq("postrst_rv", {31'd0, w_redirect_valid}, 32'd0);
            next_cyc();
        end

        // 17 stall cycles: 4-bit counter wraps to 1
        r_if_req = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check_pat("wrap", 5'b00001, 5'b00010);
            next_cyc();
        end
        r_if_req = 1'b0;
        check_eq("wrap_cnt32", w_stall_cnt, 32'd17);
        check_eq("wrap_cnt4", {28'd0, w4_stall_cnt}, exp_cnt % 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
